// File: rtl/fetch_pkg.sv
// Shared fetch types and constants: the NOP filler and the {pc, instr} queue entry.
package fetch_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetch entries with push/pop/flush and occupancy count.
// Flush wins over push; pop is ignored when empty. Pointers wrap at DEPTH (need not be 2^n).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned PW     = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  entry_t        data_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  entry_t        store_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for pointers and occupancy.
  always_comb begin
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && (count_q != '0) && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful where count covers them.
  always_ff @(posedge clk_i) begin
    if (do_push) store_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = store_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: instruction memory with load port, fetch PC, prefetch queue,
// valid/ready hand-off to decode and branch redirect flush.
// Optional build macro FETCH_PERF_EN adds saturating perf counters
// (perf_fetched, perf_stall, perf_redirect).
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     IMEM_DEPTH = 256,
  parameter int unsigned     FQ_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  localparam int unsigned    AW         = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_we,
  input  logic [AW-1:0]   load_addr,
  input  logic [XLEN-1:0] load_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] pc_out
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_stall,
  output logic [XLEN-1:0] perf_redirect
`endif
);

  localparam int unsigned CW      = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FQ_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] mem_q [IMEM_DEPTH];
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q;
  logic            inflight_q, inflight_d;
  logic            pop, issue, push;
  logic [CW:0]     occ;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  entry_t          fifo_head;
  entry_t          fifo_in;
  logic            unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // Issue/push decisions; a redirect kills the in-flight read and suppresses issue this cycle.
  always_comb begin
    pop        = !fifo_empty && out_ready;
    occ        = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    issue      = !redirect_valid && (occ < DEPTH_W);
    push       = inflight_q && !redirect_valid;
    inflight_d = issue;
    pc_d       = pc_q;
    if (redirect_valid) pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (issue)     pc_d = pc_q + XLEN'(4);
  end

  // Fetch PC and in-flight read tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= {RESET_PC[XLEN-1:2], 2'b00};
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      if (issue) inflight_pc_q <= pc_q;
    end
  end

  // Instruction memory: load-port write and read-first synchronous fetch read.
  always_ff @(posedge clk) begin
    if (load_we) mem_q[load_addr] <= load_data;
    if (issue)   rdata_q <= mem_q[pc_q[2 +: AW]];
  end

  assign fifo_in = '{pc: inflight_pc_q, instr: rdata_q};

  fetch_fifo #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  (fifo_in),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_empty ? '0 : fifo_head.pc;
  assign out_instr = fifo_empty ? XLEN'(NOP_INSTR) : fifo_head.instr;
  assign pc_out    = pc_q;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] perf_fetched_q, perf_stall_q, perf_redirect_q;

  // Saturating event counters: handshakes, stalled-head cycles, redirects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q  <= '0;
      perf_stall_q    <= '0;
      perf_redirect_q <= '0;
    end else begin
      if (pop && (perf_fetched_q != '1))
        perf_fetched_q <= perf_fetched_q + 1'b1;
      if (out_valid && !out_ready && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 1'b1;
      if (redirect_valid && (perf_redirect_q != '1))
        perf_redirect_q <= perf_redirect_q + 1'b1;
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_stall    = perf_stall_q;
  assign perf_redirect = perf_redirect_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based behavioural model.
module tb_instr_fetch_queue;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned FQ_DEPTH   = 4;
  localparam int unsigned AW         = 8;
  localparam logic [31:0] NOP        = 32'h00000013;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            load_we = 1'b0;
  logic [AW-1:0]   load_addr = '0;
  logic [XLEN-1:0] load_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc, out_instr, pc_out;
`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] perf_fetched, perf_stall, perf_redirect;
`endif

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .XLEN       (XLEN),
    .IMEM_DEPTH (IMEM_DEPTH),
    .FQ_DEPTH   (FQ_DEPTH),
    .RESET_PC   ('0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load_we        (load_we),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .pc_out         (pc_out)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_redirect  (perf_redirect)
`endif
  );

  // Behavioural model state
  logic [31:0] mem_m [IMEM_DEPTH];
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  bit          pend_v;
  logic [31:0] pend_pc, pend_ins;
  logic [31:0] pc_m;
  int unsigned perf_f, perf_s, perf_r;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_model();
    bit v;
    v = (q_pc.size() > 0);
    check_eq("out_valid", 32'(out_valid), 32'(v));
    check_eq("out_pc",    out_pc,    v ? q_pc[0]  : 32'h0);
    check_eq("out_instr", out_instr, v ? q_ins[0] : NOP);
    check_eq("pc_out",    pc_out,    pc_m);
`ifdef FETCH_PERF_EN
    check_eq("perf_fetched",  perf_fetched,  perf_f);
    check_eq("perf_stall",    perf_stall,    perf_s);
    check_eq("perf_redirect", perf_redirect, perf_r);
`endif
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_ins.delete();
    pend_v = 1'b0;
    pc_m   = 32'h0;
    perf_f = 0;
    perf_s = 0;
    perf_r = 0;
  endtask

  // One clock: drive at negedge, advance model across posedge, compare at next negedge.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc,
                      input bit we, input logic [AW-1:0] wa, input logic [31:0] wd);
    int          occ;
    bit          pop, stall, can_issue;
    logic [31:0] rd;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    load_we        = we;
    load_addr      = wa;
    load_data      = wd;
    pop       = (q_pc.size() > 0) && rdy;
    stall     = (q_pc.size() > 0) && !rdy;
    occ       = q_pc.size() + int'(pend_v) - int'(pop);
    can_issue = (occ < int'(FQ_DEPTH));
    rd        = mem_m[pc_m[2 +: AW]];
    @(posedge clk);
    if (pop) begin
      void'(q_pc.pop_front());
      void'(q_ins.pop_front());
      perf_f++;
    end
    if (stall) perf_s++;
    if (rv) begin
      q_pc.delete();
      q_ins.delete();
      pend_v = 1'b0;
      pc_m   = rpc & 32'hFFFF_FFFC;
      perf_r++;
    end else begin
      if (pend_v) begin
        q_pc.push_back(pend_pc);
        q_ins.push_back(pend_ins);
      end
      pend_v = can_issue;
      if (can_issue) begin
        pend_pc  = pc_m;
        pend_ins = rd;
        pc_m     = pc_m + 32'd4;
      end
    end
    if (we) mem_m[wa] = wd;
    @(negedge clk);
    check_model();
  endtask

  task automatic run(input bit rdy);
    step(rdy, 1'b0, 32'h0, 1'b0, '0, 32'h0);
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    step(1'b1, 1'b1, tgt, 1'b0, '0, 32'h0);
  endtask

  initial begin
    bit found;

    // Preload memory through the load port while reset is held.
    for (int unsigned i = 0; i < IMEM_DEPTH; i++) begin
      @(negedge clk);
      load_we   = 1'b1;
      load_addr = AW'(i);
      load_data = (i == 0) ? 32'h005303b3 : (i == 1) ? 32'h00628633 : $urandom;
      mem_m[i]  = load_data;
    end
    @(negedge clk);
    load_we = 1'b0;
    @(negedge clk);

    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_pc",    out_pc,    32'h0);
    check_eq("rst_instr", out_instr, NOP);
    check_eq("rst_pcout", pc_out,    32'h0);

    // Start-up latency: E1 issue, E2 first delivery.
    model_reset();
    reset = 1'b0;
    run(1'b1);
    check_eq("E1_valid", 32'(out_valid), 32'h0);
    run(1'b1);
    check_eq("E2_pc",    out_pc,    32'h0);
    check_eq("E2_instr", out_instr, 32'h005303b3);
    run(1'b1);
    check_eq("E3_pc",    out_pc,    32'h4);
    check_eq("E3_instr", out_instr, 32'h00628633);

    // Decode stall fills the queue, then back-to-back release.
    redirect_to(32'h0);
    for (int i = 0; i < 10; i++) run(1'b0);
    check_eq("full_pcout", pc_out, 32'h10);
    check_eq("full_head",  out_pc, 32'h0);
    check_eq("full_count", q_pc.size(), FQ_DEPTH);
    for (int unsigned k = 1; k <= 4; k++) begin
      run(1'b1);
      check_eq("release_pc", out_pc, 32'(4 * k));
      check_eq("release_valid", 32'(out_valid), 32'h1);
    end

    // Redirect while head is PC 8.
    redirect_to(32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid && out_pc == 32'h8) found = 1'b1;
      else run(1'b1);
    end
    check_eq("reach_pc8", 32'(found), 32'h1);
    redirect_to(32'h22);
    check_eq("redir_bubble1", 32'(out_valid), 32'h0);
    run(1'b1);
    check_eq("redir_bubble2", 32'(out_valid), 32'h0);
    run(1'b1);
    check_eq("redir_tgt", out_pc, 32'h20);
    run(1'b1);
    check_eq("redir_next", out_pc, 32'h24);

    // Address wrap: PC 0x400 reads word 0.
    redirect_to(32'h3F8);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid && out_pc == 32'h400) found = 1'b1;
      else run(1'b1);
    end
    check_eq("reach_wrap", 32'(found), 32'h1);
    check_eq("wrap_instr", out_instr, 32'h005303b3);

    // Randomized traffic: varying ready density, occasional redirects and loads.
    for (int blk = 0; blk < 20; blk++) begin
      int unsigned dens;
      dens = $urandom_range(0, 4);
      for (int i = 0; i < 100; i++) begin
        step(($urandom_range(0, 4) < dens) || (dens == 4),
             ($urandom_range(0, 31) == 0),
             $urandom,
             ($urandom_range(0, 7) == 0),
             AW'($urandom),
             $urandom);
      end
    end

    // Asynchronous reset with a full queue.
    for (int i = 0; i < 8; i++) run(1'b0);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'h0);
    check_eq("arst_pc",    out_pc,    32'h0);
    check_eq("arst_instr", out_instr, NOP);
    check_eq("arst_pcout", pc_out,    32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    run(1'b1);
    run(1'b1);
    check_eq("restart_pc",    out_pc,    32'h0);
    check_eq("restart_valid", 32'(out_valid), 32'h1);
    check_eq("restart_instr", out_instr, mem_m[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Parametrised instruction fetch unit for the RISC-V core: owns the instruction memory, the fetch PC and a prefetch queue, and hands `{pc, instr}` pairs to decode over a valid/ready handshake. It adds three things a single-PC fetch stage lacks: a synthesizable load port (memory is preloaded through ports, not hierarchical writes), a configurable-depth queue that decouples fetch from decode stalls, and a branch redirect that flushes in-flight work.

## Interface
- `XLEN`, 32, data/address width
- `IMEM_DEPTH`, 256, instruction memory words (power of two); `AW = $clog2(IMEM_DEPTH)`
- `FQ_DEPTH`, 4, prefetch queue entries (>= 2)
- `RESET_PC`, 0, first fetch address
- `clk` in 1, rising-edge clock
- `reset` in 1, asynchronous, active-high
- `load_we` in 1, memory write strobe
- `load_addr` in AW, word address
- `load_data` in XLEN, word to write
- `redirect_valid` in 1, branch/jump redirect
- `redirect_pc` in XLEN, redirect target
- `out_valid` out 1, queue head valid
- `out_ready` in 1, decode accepts head
- `out_pc` out XLEN, PC of head entry
- `out_instr` out XLEN, instruction of head entry
- `pc_out` out XLEN, next address to be fetched

## Operation
- Memory: single-port write (`load_*`), one synchronous read port, 1-cycle latency, read-first: a same-cycle write to the address being read returns the old word.
- Index = `pc[2 +: AW]`; addresses wrap modulo `IMEM_DEPTH*4`. Bits `[1:0]` of `pc` and `redirect_pc` are ignored (forced 0).
- Issue: each cycle a read of `pc_out` is issued and `pc_out += 4` when `count + inflight - pop < FQ_DEPTH` (`pop = out_valid & out_ready`). `inflight` is 0/1.
- Response: the issued word is pushed next cycle together with its PC.
- Handshake: entry consumed when `out_valid & out_ready` at a rising edge. `out_valid` never drops without a pop or redirect; `out_pc/out_instr` stable while `out_valid & !out_ready`.
- Empty queue: `out_valid=0`, `out_pc=0`, `out_instr=32'h00000013` (NOP).
- Redirect: queue cleared, in-flight read killed (not pushed), `pc_out <= {redirect_pc[XLEN-1:2],2'b00}`. Redirect wins over issue and push in that cycle; a same-cycle pop still counts as accepted by decode.
- Full queue with `out_ready=0`: no issue, `pc_out` holds, no entry lost or duplicated.
- Load writes are permitted while fetching; no coherence with queued entries.

## Timing
- Reset (async assert): queue empty, `inflight=0`, `out_valid=0`, `out_pc=0`, `out_instr=NOP`, `pc_out=RESET_PC`, perf counters 0. Reset mid-operation discards everything.
- Edge E1 (first with reset low): read of `RESET_PC` issued. E2: `out_valid=1`, `out_pc=RESET_PC`.
- Steady state, `out_ready=1`: one instruction per cycle, PCs increment by 4.
- Redirect sampled at edge R: R+1 issue of target; R+2 `out_valid=1` with target PC. Two-cycle bubble.
- `out_ready` low for N cycles: queue fills to `FQ_DEPTH` then issue stops; on release, back-to-back delivery resumes with no gap.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perf_fetched` (XLEN, handshakes), `perf_stall` (XLEN, cycles with `out_valid & !out_ready`), `perf_redirect` (XLEN, redirects); all saturate at all-ones, reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Structure
- `fetch_pkg`: `NOP_INSTR = 32'h00000013`, `fetch_entry_t` struct `{pc, instr}` (XLEN each), default `XLEN`.
- One sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, `FQ_DEPTH` entries, push/pop/flush, count output, pointer wrap.
- Memory, PC, issue logic and perf counters in the top.

## Test plan
- Load [0]=0x005303b3, [1]=0x00628633, release reset, `out_ready=1` -> E2 `out_pc=0, out_instr=0x005303b3`; E3 `out_pc=4, out_instr=0x00628633`.
- `out_ready=0` for 10 cycles, `FQ_DEPTH=4` -> queue holds PCs 0,4,8,C, `pc_out=0x10`, head stable; release -> PCs 0,4,8,C,10 on consecutive cycles.
- At head PC 8, `redirect_valid=1, redirect_pc=0x22` -> next two cycles `out_valid=0`, then `out_pc=0x20`, then 0x24; no 0xC delivered.
- Fetch to `pc=IMEM_DEPTH*4` (0x400) -> returns word [0] with `out_pc=0x400`.
- Assert `reset` while queue full -> `out_valid=0`, `out_instr=0x00000013`, `pc_out=RESET_PC` immediately; restart from `RESET_PC` after release.
- With `FETCH_PERF_EN`: 5 accepted, 3 stall cycles, 1 redirect -> `perf_fetched=5, perf_stall=3, perf_redirect=1`.
